// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmem_ctrl_pkg
// Brief    : State encoding, access-size codes and lane helpers for the
//            data-memory access controller.
// Revision : 1.0
// ============================================================================
package dmem_ctrl_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ0  = 3'd1;
    localparam logic [2:0] ST_WAIT0 = 3'd2;
    localparam logic [2:0] ST_REQ1  = 3'd3;
    localparam logic [2:0] ST_WAIT1 = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [1:0] SIZE_W = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_B = 2'b10;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_W:  return 4'b1111;
            SIZE_H:  return 4'b0011;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic logic size_illegal(input logic [1:0] size);
        return size == 2'b11;
    endfunction

    // An access crosses a word boundary when offset + byte count exceeds 4.
    function automatic logic is_crossing(input logic [1:0] size, input logic [1:0] k);
        case (size)
            SIZE_W:  return k != 2'd0;
            SIZE_H:  return k == 2'd3;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Byte-enable generation, store-data rotation and two-beat read
//            merge for the data-memory access controller.
// Revision : 1.0
// ============================================================================
module dmem_lane_align
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata0_i,
    input  logic [23:0] rdata1_i,
    output logic [3:0]  be0_o,
    output logic [3:0]  be1_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  w_be_wide;
    logic [31:0] w_rd_shift;
    logic [31:0] w_rd_mask;

    always_comb begin
        w_be_wide = {4'b0000, size_mask(size_i)} << offset_i;
        be0_o     = w_be_wide[3:0];
        be1_o     = w_be_wide[7:4];

        // Rotate left by 8*offset; read path is the matching right shift of {rdata1,rdata0}.
        case (offset_i)
            2'd0: begin
                wdata_o    = wdata_i;
                w_rd_shift = rdata0_i;
            end
            2'd1: begin
                wdata_o    = {wdata_i[23:0], wdata_i[31:24]};
                w_rd_shift = {rdata1_i[7:0], rdata0_i[31:8]};
            end
            2'd2: begin
                wdata_o    = {wdata_i[15:0], wdata_i[31:16]};
                w_rd_shift = {rdata1_i[15:0], rdata0_i[31:16]};
            end
            default: begin
                wdata_o    = {wdata_i[7:0], wdata_i[31:8]};
                w_rd_shift = {rdata1_i[23:0], rdata0_i[31:24]};
            end
        endcase

        case (size_i)
            SIZE_W:  w_rd_mask = 32'hFFFF_FFFF;
            SIZE_H:  w_rd_mask = 32'h0000_FFFF;
            default: w_rd_mask = 32'h0000_00FF;
        endcase
        rdata_o = w_rd_shift & w_rd_mask;
    end

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : Sequences core loads/stores onto the req/gnt/rvalid data bus,
//            splitting word-crossing accesses and timing out hung beats.
// Revision : 1.0
// ============================================================================
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int MISALIGN_EN = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        we_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] rdata0_q;
    logic [23:0] rdata1_q;
    logic        rsp_valid_q, rsp_err_q, stall_q;
    logic [31:0] rsp_rdata_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_be_q;

    logic        w_idle, w_timeout, w_reject;
    logic [1:0]  w_size, w_off;
    logic [3:0]  w_be0, w_be1;
    logic [31:0] w_wrot, w_rdata;

    assign w_idle    = state_q == ST_IDLE;
    assign w_timeout = cnt_q == TMO_LAST;
    assign w_reject  = size_illegal(req_size) ||
                       ((MISALIGN_EN == 0) && is_crossing(req_size, req_addr[1:0]));

    // Lane logic sees the live request while idle so beat 0 can be registered at accept.
    assign w_size = w_idle ? req_size      : size_q;
    assign w_off  = w_idle ? req_addr[1:0] : off_q;

    dmem_lane_align u_align (
        .size_i   (w_size),
        .offset_i (w_off),
        .wdata_i  (req_wdata),
        .rdata0_i (rdata0_q),
        .rdata1_i (rdata1_q),
        .be0_o    (w_be0),
        .be1_o    (w_be1),
        .wdata_o  (w_wrot),
        .rdata_o  (w_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    err_d   = w_reject;
                    state_d = w_reject ? ST_DONE : ST_REQ0;
                end
            end
            ST_REQ0, ST_REQ1: begin
                if (mem_gnt) begin
                    state_d = (state_q == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
                end else if (w_timeout) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT0, ST_WAIT1: begin
                if (mem_rvalid) begin
                    state_d = (state_q == ST_WAIT0 && is_crossing(size_q, off_q)) ? ST_REQ1 : ST_DONE;
                end else if (w_timeout) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            stall_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            rsp_valid_q <= state_q == ST_DONE;
            rsp_err_q   <= (state_q == ST_DONE) && err_q;
            rsp_rdata_q <= (state_q == ST_DONE && !we_q) ? w_rdata : '0;

            if (w_idle && req_valid) begin
                we_q     <= req_we;
                size_q   <= req_size;
                off_q    <= req_addr[1:0];
                rdata0_q <= '0;
                rdata1_q <= '0;
                stall_q  <= 1'b1;
            end else if (rsp_valid_q) begin
                stall_q  <= 1'b0;
            end

            if (w_idle && state_d == ST_REQ0) begin
                mem_we_q    <= req_we;
                mem_addr_q  <= {req_addr[31:2], 2'b00};
                mem_be_q    <= w_be0;
                mem_wdata_q <= w_wrot;
            end else if (state_q == ST_WAIT0 && state_d == ST_REQ1) begin
                mem_addr_q  <= mem_addr_q + 32'd4;
                mem_be_q    <= w_be1;
            end

            if (state_q == ST_WAIT0 && mem_rvalid) rdata0_q <= mem_rdata;
            if (state_q == ST_WAIT1 && mem_rvalid) rdata1_q <= mem_rdata[23:0];
        end
    end

    assign req_ready = w_idle;
    assign stall     = stall_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_req   = (state_q == ST_REQ0) || (state_q == ST_REQ1);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire
